// File: rtl/uart_line_receiver.sv
// rtl/uart_line_receiver.sv - assembles received bytes into terminated lines for a byte-wise reader
module uart_line_receiver #(
    parameter int MAX_LEN = 20,
    parameter int LEN_W = 5,
    parameter logic [7:0] TERM = 8'h0A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             received,
    input  logic             recv_error,
    input  logic             rd_en,
    input  logic             clr_flags,
    output logic             line_ready,
    output logic [LEN_W-1:0] line_len,
    output logic [7:0]       rd_data,
    output logic             overflow,
    output logic             overrun,
    output logic [7:0]       err_count
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    logic [1:0]       state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] rd_ptr;
    logic [7:0]       buffer [MAX_LEN];

    logic byte_ev;
    logic is_term;
    logic store_byte;
    logic overflow_set;
    logic overrun_set;
    logic last_pop;

    assign byte_ev      = received && !recv_error;
    assign is_term      = (rx_byte == TERM);
    assign store_byte   = (state == S_COLLECT) && byte_ev && !is_term && (count < MAX_LEN_C);
    assign overflow_set = (state == S_COLLECT) && byte_ev && !is_term && (count == MAX_LEN_C);
    assign overrun_set  = (state == S_READY) && byte_ev;
    assign last_pop     = rd_en && (rd_ptr == line_len - LEN_W'(1));

    assign rd_data = buffer[rd_ptr];

    // Buffer contents are don't-care after reset, so it sits outside the reset domain
    always_ff @(posedge clk) begin
        if (store_byte) begin
            buffer[count] <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_COLLECT;
            count      <= '0;
            rd_ptr     <= '0;
            line_len   <= '0;
            line_ready <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (recv_error) begin
                        count <= '0;
                        state <= S_DISCARD;
                    end else if (received) begin
                        if (is_term) begin
                            if (count != '0) begin
                                line_len   <= count;
                                line_ready <= 1'b1;
                                rd_ptr     <= '0;
                                state      <= S_READY;
                            end
                        end else if (count < MAX_LEN_C) begin
                            count <= count + LEN_W'(1);
                        end else begin
                            state <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (byte_ev && is_term) begin
                        count <= '0;
                        state <= S_COLLECT;
                    end
                end
                S_READY: begin
                    if (last_pop) begin
                        line_ready <= 1'b0;
                        line_len   <= '0;
                        rd_ptr     <= '0;
                        count      <= '0;
                        state      <= S_COLLECT;
                    end else if (rd_en) begin
                        rd_ptr <= rd_ptr + LEN_W'(1);
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    // A setting event in the same cycle as clr_flags takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            overrun   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (recv_error) begin
                if (clr_flags) begin
                    err_count <= 8'd1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (clr_flags) begin
                err_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_line_receiver.sv
// tb/tb_uart_line_receiver.sv - directed scoreboard bench for uart_line_receiver
module tb_uart_line_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       received = 1'b0;
    logic       recv_error = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_flags = 1'b0;
    logic       line_ready;
    logic [4:0] line_len;
    logic [7:0] rd_data;
    logic       overflow;
    logic       overrun;
    logic [7:0] err_count;

    int vectors = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    uart_line_receiver #(.MAX_LEN(20), .LEN_W(5), .TERM(8'h0A)) dut (
        .clk(clk),
        .rst(rst),
        .rx_byte(rx_byte),
        .received(received),
        .recv_error(recv_error),
        .rd_en(rd_en),
        .clr_flags(clr_flags),
        .line_ready(line_ready),
        .line_len(line_len),
        .rd_data(rd_data),
        .overflow(overflow),
        .overrun(overrun),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err, input int gap);
        @(posedge clk); #1;
        rx_byte    = b;
        received   = !err;
        recv_error = err;
        @(posedge clk); #1;
        received   = 1'b0;
        recv_error = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s, input bit expect_line);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b0, 0);
            if (expect_line && s[i] != 8'h0A) exp_q.push_back(s[i]);
        end
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic read_line(input string tag, input int exp_len);
        int waited;
        waited = 0;
        while (!line_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_ready"}, {31'd0, line_ready}, 32'd1);
        check({tag, "_len"}, {27'd0, line_len}, exp_len);
        for (int i = 0; i < exp_len; i++) pop_one({tag, "_data"});
        check({tag, "_done"}, {31'd0, line_ready}, 32'd0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, line_ready}, 32'd0);
        check("rst_len", {27'd0, line_len}, 32'd0);
        check("rst_errcnt", {24'd0, err_count}, 32'd0);
        rst = 1'b0;

        // 1: spaced strobes, latency of line_ready
        send_byte("E", 1'b0, 10); send_byte("S", 1'b0, 10);
        send_byte("K", 1'b0, 10); send_byte("E", 1'b0, 10);
        exp_q.push_back("E"); exp_q.push_back("S"); exp_q.push_back("K"); exp_q.push_back("E");
        @(posedge clk); #1;
        rx_byte = 8'h0A; received = 1'b1;
        @(negedge clk);
        check("t1_ready_before", {31'd0, line_ready}, 32'd0);
        @(posedge clk); #1;
        received = 1'b0;
        check("t1_ready_lat1", {31'd0, line_ready}, 32'd1);
        read_line("t1", 4);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_overrun", {31'd0, overrun}, 32'd0);

        // 2: overlong line discarded
        for (int i = 0; i < 21; i++) send_byte("A", 1'b0, 0);
        send_byte(8'h0A, 1'b0, 2);
        check("t2_overflow", {31'd0, overflow}, 32'd1);
        check("t2_no_line", {31'd0, line_ready}, 32'd0);
        send_str("HI\n", 1'b1);
        read_line("t2", 2);

        // 3: framing error abandons partial line
        send_str("AB", 1'b0);
        send_byte(8'h00, 1'b1, 0);
        send_str("C\n", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t3_errcnt", {24'd0, err_count}, 32'd1);
        check("t3_no_line", {31'd0, line_ready}, 32'd0);
        send_str("XY\n", 1'b1);
        read_line("t3", 2);

        // 4: bytes arriving while a line is held
        pulse_clr();
        send_str("OK\n", 1'b1);
        send_byte("Z", 1'b0, 0);
        check("t4_overrun_held", {31'd0, overrun}, 32'd1);
        check("t4_len_kept", {27'd0, line_len}, 32'd2);
        pulse_clr();
        check("t4_overrun_clr", {31'd0, overrun}, 32'd0);
        pop_one("t4_data");
        check("t4_data_last", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        rd_en = 1'b1; received = 1'b1; rx_byte = "Z";
        @(posedge clk); #1;
        rd_en = 1'b0; received = 1'b0;
        check("t4_overrun_lastpop", {31'd0, overrun}, 32'd1);
        check("t4_ready_after", {31'd0, line_ready}, 32'd0);
        send_str("Q\n", 1'b1);
        read_line("t4q", 1);
        pulse_clr();
        check("t4_overrun_clr2", {31'd0, overrun}, 32'd0);
        check("t4_overflow_clr", {31'd0, overflow}, 32'd0);

        // 5: empty lines suppressed
        send_str("\n\n\n", 1'b0);
        check("t5_no_empty", {31'd0, line_ready}, 32'd0);
        send_str("T\n", 1'b1);
        read_line("t5", 1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_single", {31'd0, line_ready}, 32'd0);

        // 6: reset drops a held line asynchronously, then mid-line
        send_str("W\n", 1'b0);
        check("t6_held", {31'd0, line_ready}, 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t6_async_drop", {31'd0, line_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_str("ES", 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_str("D\n", 1'b1);
        read_line("t6", 1);
        for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b1, 0);
        check("t6_errcnt_sat", {24'd0, err_count}, 32'd255);
        @(posedge clk); #1;
        clr_flags = 1'b1; recv_error = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0; recv_error = 1'b0;
        check("t6_clr_set_wins", {24'd0, err_count}, 32'd1);
        pulse_clr();
        check("t6_errcnt_clr", {24'd0, err_count}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/uart_line_receiver.md
Name: uart_line_receiver

Overview:
Receive-side counterpart to the UART string transmitter. Consumes the byte strobes from the shared `uart` receiver, assembles printable bytes into a line buffer up to a terminator (default '\n') and presents the completed line to a downstream reader one byte per pop. Lines that are too long or corrupted are discarded whole. Sticky status flags and an error counter support debugging.

Parameters:
MAX_LEN, 20, line buffer depth in bytes (maximum stored line length, terminator excluded)
LEN_W, 5, width of the length and pointer fields; must satisfy 2^LEN_W > MAX_LEN
TERM, 8'h0A, line terminator byte

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
rx_byte  in  8  byte from `uart`; valid only while `received`=1
received  in  1  one-cycle strobe: rx_byte valid
recv_error  in  1  one-cycle strobe from `uart`: framing error on the current byte
rd_en  in  1  reader pops the current rd_data; ignored unless line_ready=1
clr_flags  in  1  synchronous clear of overflow, overrun and err_count
line_ready  out  1  a complete line is held; rd_data is valid
line_len  out  LEN_W  length of the held line (1..MAX_LEN); 0 when line_ready=0
rd_data  out  8  buffer[rd_ptr]; combinational from the registered pointer
overflow  out  1  sticky: a line exceeded MAX_LEN and was discarded
overrun  out  1  sticky: a byte arrived while a line was held and was dropped
err_count  out  8  count of recv_error strobes; saturates at 255

Behaviour:
- Reset (async):
  - State goes to COLLECT.
  - count, rd_ptr, line_len, line_ready, overflow, overrun and err_count go to 0.
  - rd_data reads buffer[0]. Buffer contents are don't-care.
- Byte event = received=1 and recv_error=0.
- Error event = recv_error=1, regardless of `received`.
  - err_count increments, saturating at 255.
  - The byte is never stored.
- COLLECT:
  - Byte event with rx_byte≠TERM and count<MAX_LEN: buffer[count]<=rx_byte; count++.
  - Byte event with rx_byte≠TERM and count==MAX_LEN: overflow<=1; state goes to DISCARD.
  - Byte event with rx_byte==TERM and count==0: ignored (empty lines are suppressed); state stays COLLECT.
  - Byte event with rx_byte==TERM and count>0: line_len<=count; line_ready<=1; rd_ptr<=0; state goes to READY. The terminator is not stored.
  - line_ready rises the cycle after the terminator strobe (latency 1).
  - Error event: count<=0; state goes to DISCARD (the partial line is abandoned).
- DISCARD:
  - All non-TERM bytes are ignored.
  - Byte event with TERM: count<=0; state goes to COLLECT.
  - Error event: stays in DISCARD.
- READY:
  - rd_en=1 with rd_ptr<line_len-1: rd_ptr++.
  - rd_en=1 with rd_ptr==line_len-1 (last pop): line_ready<=0; line_len<=0; rd_ptr<=0; count<=0; state goes to COLLECT.
  - Byte event: byte dropped; overrun<=1. This includes a TERM byte and a byte arriving in the same cycle as the last pop (the state is still READY in that cycle).
  - Error event: counted only; the held line is unaffected.
- Pops:
  - One byte per rd_en cycle.
  - rd_data updates the cycle after each pop.
  - rd_en with line_ready=0 has no effect.
- clr_flags:
  - Clears overflow, overrun and err_count next cycle.
  - If clr_flags and a setting event occur in the same cycle, the set wins. For err_count, that cycle's result is 1.
  - No effect on line state.
- Wrap and limits:
  - count never exceeds MAX_LEN.
  - err_count never wraps.
- Reset mid-operation: any in-progress or held line is lost immediately; line_ready drops asynchronously.

Test Plan:
1. Send "ESKE\n" as 5 strobes spaced 10 cycles apart -> line_ready=1 one cycle after the '\n' strobe; line_len=4. Four rd_en pops read 'E','S','K','E'. line_ready=0 after the 4th pop. overflow=0, overrun=0.
2. Send 21 'A' bytes then '\n' (MAX_LEN=20) -> overflow=1 and line_ready stays 0. A following "HI\n" yields line_len=2 and data 'H','I'.
3. Send "AB", then pulse recv_error, then "C\n" -> err_count=1 and no line is produced. A following "XY\n" yields line_len=2.
4. With line "OK" held, send 'Z', including one instance in the same cycle as the final rd_en pop -> 'Z' is dropped and overrun=1. The next line "Q\n" is captured normally. clr_flags then gives overrun=0.
5. Send "\n\n\nT\n" -> exactly one line is produced, line_len=1, data 'T'.
6. Assert rst mid-line after "ES", then send "D\n" -> line_len=1, data 'D'. Pulse recv_error 260 times -> err_count=255.
